// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, coefficient set and types for the streaming FIR core.
//   DW / CW     sample and coefficient widths (signed)
//   NTAPS       number of filter taps
//   AW          accumulator width, wide enough that the full dot product never wraps
//   FIR_COEFFS  c[0..NTAPS-1], applied as c[k] * x[k] with x[0] the newest sample
package fir_pkg;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int NTAPS = 4;
    localparam int AW    = DW + CW + $clog2(NTAPS);

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [CW-1:0] coeff_t;
    typedef logic signed [AW-1:0] acc_t;

    localparam coeff_t FIR_COEFFS [NTAPS] = '{
        coeff_t'(2), coeff_t'(3), coeff_t'(-2), coeff_t'(8)
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round-half-up right shift followed by saturation
// of the accumulator to the signed output range.
//   acc     in   AW  signed accumulator value
//   result  out  DW  signed rounded and clamped value
// SHIFT = 0 passes the accumulator straight to the clamp.
module fir_round_sat
#(
    parameter int AW    = fir_pkg::AW,
    parameter int DW    = fir_pkg::DW,
    parameter int SHIFT = 0
)
(
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] result
);

    // Output range limits, sign-extended to the accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] rounded;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (SHIFT-1);
            // Headroom above the largest possible dot product keeps the +HALF from wrapping.
            assign rounded = (acc + HALF) >>> SHIFT;
        end else begin : g_pass
            assign rounded = acc;
        end
    endgenerate

    always_comb begin
        result = rounded[DW-1:0];
        if (rounded > SAT_MAX) begin
            result = {1'b0, {(DW-1){1'b1}}};
        end else if (rounded < SAT_MIN) begin
            result = {1'b1, {(DW-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fir_stream_core.sv
// fir_stream_core: streaming signed FIR filter with one time-multiplexed MAC.
// One sample is accepted per valid/ready handshake; the dot product with
// fir_pkg::FIR_COEFFS is accumulated one tap per cycle and the rounded,
// saturated result is presented on a valid/ready output.
//   system1000       in   1   clock, rising edge
//   system1000_rstn  in   1   asynchronous active-low reset
//   in_valid         in   1   arg holds a sample
//   in_ready         out  1   core can accept a sample (IDLE only)
//   arg              in   DW  signed input sample
//   out_valid        out  1   result holds a filtered value (OUT only)
//   out_ready        in   1   consumer takes result
//   result           out  DW  signed filtered output, stable while out_valid
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a sample; accept shifts the delay line, clears acc
// MAC   | one tap per cycle: acc += c[tap] * x[tap]; last tap loads result
// OUT   | result presented; leaves on out_ready
module fir_stream_core
#(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int DW    = fir_pkg::DW,
    parameter int CW    = fir_pkg::CW,
    parameter int SHIFT = 0
)
(
    input  logic                 system1000,
    input  logic                 system1000_rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] arg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] result
);

    import fir_pkg::*;

    localparam int AW = DW + CW + $clog2(NTAPS);
    localparam int PW = DW + CW;
    localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    fsm_state_t           state;
    logic [KW-1:0]        tap;
    logic signed [DW-1:0] x [NTAPS];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [CW-1:0] coef;
    logic signed [DW-1:0] x_sel;
    logic signed [PW-1:0] coef_ext;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] rs_out;

    assign coef  = FIR_COEFFS[tap];
    assign x_sel = x[tap];

    // Both factors are widened to the full product width so the multiply is exact.
    assign coef_ext = {{DW{coef[CW-1]}}, coef};
    assign x_ext    = {{CW{x_sel[DW-1]}}, x_sel};
    assign prod     = coef_ext * x_ext;
    assign acc_next = acc + {{(AW-PW){prod[PW-1]}}, prod};

    // The final tap's sum goes straight into round/saturate so result is
    // registered on the same edge that completes the MAC.
    fir_round_sat #(
        .AW    (AW),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc    (acc_next),
        .result (rs_out)
    );

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= IDLE;
            tap       <= '0;
            acc       <= '0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x[0] <= arg;
                        for (int i = 1; i < NTAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        acc      <= '0;
                        tap      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap == KW'(NTAPS-1)) begin
                        result    <= rs_out;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_core.sv
module tb_fir_stream_core;

    localparam int NTAPS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [15:0] arg = '0;

    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic signed [15:0] result0, result1;

    int tests_run = 0;
    int tests_failed = 0;

    int coef [NTAPS] = '{2, 3, -2, 8};
    longint hist [$];

    always #5 clk = ~clk;

    fir_stream_core #(.SHIFT(0)) dut0 (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready0),
        .arg             (arg),
        .out_valid       (out_valid0),
        .out_ready       (out_ready),
        .result          (result0)
    );

    fir_stream_core #(.SHIFT(1)) dut1 (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready1),
        .arg             (arg),
        .out_valid       (out_valid1),
        .out_ready       (out_ready),
        .result          (result1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: y = sat(round(sum c[i] * x[i])) over the last NTAPS accepted samples.
    function automatic void model_reset();
        hist.delete();
    endfunction

    function automatic void model_push(input int s);
        hist.push_front(longint'(s));
        if (hist.size() > NTAPS) void'(hist.pop_back());
    endfunction

    function automatic int model_out(input int shift);
        longint acc = 0;
        longint v;
        for (int i = 0; i < hist.size(); i++) acc += coef[i] * hist[i];
        if (shift > 0) v = (acc + (longint'(1) << (shift - 1))) >>> shift;
        else v = acc;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Offer one sample, wait for its result, hold out_ready low for 'hold'
    // cycles, then transfer. Returns at the negedge after the transfer edge.
    task automatic xfer(input int s, input int hold, output int r0, output int r1,
                        output int lat, output bit ok);
        int n;
        ok = 1'b1; lat = 0; r0 = 0; r1 = 0;
        @(negedge clk);
        in_valid = 1'b1;
        arg = 16'(s);
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(s);
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid0 && lat < 50);
        if (!out_valid0) begin
            ok = 1'b0;
            return;
        end
        r0 = result0;
        r1 = result1;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || result0 !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%0d, expected 1 0 0",
                     in_ready0, out_valid0, result0);
        end
        tests_run++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || result1 !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_state_shift1: in_ready=%b out_valid=%b result=%0d, expected 1 0 0",
                     in_ready1, out_valid1, result1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_impulse();
        int exp0 [5] = '{2, 3, -2, 8, 0};
        int stim [5] = '{1, 0, 0, 0, 0};
        int r0, r1, lat;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            xfer(stim[i], 0, r0, r1, lat, ok);
            tests_run++;
            if (!ok || r0 != exp0[i] || lat != NTAPS + 1) begin
                tests_failed++;
                $display("FAIL impulse[%0d]: ok=%0b result=%0d latency=%0d, expected %0d latency %0d",
                         i, ok, r0, lat, exp0[i], NTAPS + 1);
            end
            tests_run++;
            if (r1 != model_out(1)) begin
                tests_failed++;
                $display("FAIL impulse_shift1[%0d]: result=%0d expected %0d", i, r1, model_out(1));
            end
            tests_run++;
            if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL impulse_after[%0d]: in_ready=%b out_valid=%b expected 1 0",
                         i, in_ready0, out_valid0);
            end
        end
    endtask

    task automatic test_step();
        int exp0 [5] = '{2, 5, 3, 11, 11};
        int r0, r1, lat;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            xfer(1, 0, r0, r1, lat, ok);
            tests_run++;
            if (!ok || r0 != exp0[i]) begin
                tests_failed++;
                $display("FAIL step[%0d]: ok=%0b result=%0d expected %0d", i, ok, r0, exp0[i]);
            end
            tests_run++;
            if (r1 != model_out(1)) begin
                tests_failed++;
                $display("FAIL step_shift1[%0d]: result=%0d expected %0d", i, r1, model_out(1));
            end
        end
    endtask

    task automatic test_saturation();
        int r0, r1, lat;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            xfer(32767, 0, r0, r1, lat, ok);
            tests_run++;
            if (!ok || r0 != 32767 || r1 != 32767) begin
                tests_failed++;
                $display("FAIL sat_pos[%0d]: ok=%0b result=%0d/%0d expected 32767", i, ok, r0, r1);
            end
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            xfer(-32768, 0, r0, r1, lat, ok);
            tests_run++;
            if (!ok || r0 != -32768 || r1 != -32768) begin
                tests_failed++;
                $display("FAIL sat_neg[%0d]: ok=%0b result=%0d/%0d expected -32768", i, ok, r0, r1);
            end
        end
    endtask

    task automatic test_shift_impulse();
        int exp1 [4] = '{3, 5, -3, 12};
        int stim [4] = '{3, 0, 0, 0};
        int r0, r1, lat;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            xfer(stim[i], 1, r0, r1, lat, ok);
            tests_run++;
            if (!ok || r1 != exp1[i]) begin
                tests_failed++;
                $display("FAIL shift1_impulse[%0d]: ok=%0b result=%0d expected %0d", i, ok, r1, exp1[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] held;
        int n;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        arg = 16'sd5;
        @(posedge clk);
        model_push(5);
        @(negedge clk);
        arg = -16'sd9;
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = result0;
        tests_run++;
        if (out_valid0 !== 1'b1 || held != 16'(model_out(0))) begin
            tests_failed++;
            $display("FAIL bp_first: out_valid=%b result=%0d expected 1 %0d", out_valid0, held, model_out(0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (result0 !== held || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: result=%0d out_valid=%b in_ready=%b expected %0d 1 0",
                         i, result0, out_valid0, in_ready0, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready0, out_valid0);
        end
        @(posedge clk);
        model_push(-9);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (out_valid0 !== 1'b1 || result0 != 16'(model_out(0)) || result1 != 16'(model_out(1))) begin
            tests_failed++;
            $display("FAIL bp_pending: out_valid=%b result=%0d/%0d expected %0d/%0d",
                     out_valid0, result0, result1, model_out(0), model_out(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mac();
        int r0, r1, lat;
        bit ok;
        do_reset();
        xfer(1, 0, r0, r1, lat, ok);
        @(negedge clk);
        in_valid = 1'b1;
        arg = 16'sd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid0 !== 1'b0 || result0 !== 16'sd0 || in_ready0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_mac: out_valid=%b result=%0d in_ready=%b expected 0 0 1",
                     out_valid0, result0, in_ready0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        xfer(1, 0, r0, r1, lat, ok);
        tests_run++;
        if (!ok || r0 != 2 || r1 != 1) begin
            tests_failed++;
            $display("FAIL reset_cleared_line: ok=%0b result=%0d/%0d expected 2/1", ok, r0, r1);
        end
    endtask

    task automatic test_random();
        int r0, r1, lat, s, hold, gap;
        bit ok;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: s = 32767;
                1: s = -32768;
                default: s = int'($urandom_range(0, 65535)) - 32768;
            endcase
            hold = $urandom_range(0, 3);
            gap = $urandom_range(0, 2);
            // out_ready outside OUT must not disturb the idle core.
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                out_ready = 1'b1;
            end
            @(negedge clk);
            out_ready = 1'b0;
            tests_run++;
            if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_idle[%0d]: in_ready=%b out_valid=%b expected 1 0", i, in_ready0, out_valid0);
            end
            xfer(s, hold, r0, r1, lat, ok);
            tests_run++;
            if (!ok || r0 != model_out(0) || r1 != model_out(1) || lat != NTAPS + 1) begin
                tests_failed++;
                $display("FAIL rand[%0d]: ok=%0b arg=%0d result=%0d/%0d latency=%0d expected %0d/%0d latency %0d",
                         i, ok, s, r0, r1, lat, model_out(0), model_out(1), NTAPS + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_saturation();
        test_shift_impulse();
        test_backpressure();
        test_reset_mid_mac();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
